// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared register map, ctrl bit positions and scan state type
package led_pwm_pkg;

    localparam logic [7:0] ADDR_TARGET_BASE = 8'h00;
    localparam logic [7:0] ADDR_RATE        = 8'h08;
    localparam logic [7:0] ADDR_CTRL        = 8'h09;
    localparam logic [7:0] ADDR_LEVEL_BASE  = 8'h10;

    localparam int CTRL_FADE_EN = 0;
    localparam int CTRL_FREEZE  = 1;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

endpackage

// File: rtl/led_fade_engine_if.sv
// rtl/led_fade_engine_if.sv - register write/read port between the I2C slave and the fade engine
interface led_fade_engine_if;

    logic       wen;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output wen, output addr, output wdata, input rdata);
    modport slave  (input wen, input addr, input wdata, output rdata);

endinterface

// File: rtl/led_fade_engine_prescaler.sv
// rtl/led_fade_engine_prescaler.sv - fade_prescaler: programmable tick generator for the scan FSM
module fade_prescaler #(
    parameter int PRESCALE_LSB = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rate,
    input  logic       rate_wr,
    input  logic       freeze,
    output logic       tick
);

    localparam int CW = 8 + PRESCALE_LSB;

    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;

    assign limit = {rate, {PRESCALE_LSB{1'b1}}};
    // A rate write restarts the period, so no tick escapes on the old limit.
    assign tick  = !freeze && !rate_wr && (cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rate_wr) begin
            cnt <= '0;
        end else if (!freeze) begin
            if (cnt == limit) cnt <= '0;
            else              cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_fade_engine.sv
// rtl/led_fade_engine.sv - register-mapped per-channel fade engine feeding the PWM value inputs
module led_fade_engine
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int PRESCALE_LSB = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_fade_engine_if.slave      bus,
    output logic [8*NUM_CH-1:0]   level,
    output logic                  settled,
    output logic                  busy
);

    localparam int PW = $clog2(NUM_CH);

    logic [7:0]    target_r [NUM_CH];
    logic [7:0]    level_r  [NUM_CH];
    logic [7:0]    rate_r;
    logic [1:0]    ctrl_r;
    logic          copy_pending;
    scan_state_t   state;
    logic [PW-1:0] ptr;
    logic          tick;
    logic          all_eq;

    logic          tgt_wr, rate_wr, ctrl_wr, tgt_rd, lvl_rd;
    logic [PW-1:0] tgt_idx, lvl_idx;

    assign tgt_rd  = (bus.addr < ADDR_TARGET_BASE + 8'(NUM_CH));
    assign lvl_rd  = (bus.addr >= ADDR_LEVEL_BASE) && (bus.addr < ADDR_LEVEL_BASE + 8'(NUM_CH));
    assign tgt_idx = PW'(bus.addr - ADDR_TARGET_BASE);
    assign lvl_idx = PW'(bus.addr - ADDR_LEVEL_BASE);
    assign tgt_wr  = bus.wen && tgt_rd;
    assign rate_wr = bus.wen && (bus.addr == ADDR_RATE);
    assign ctrl_wr = bus.wen && (bus.addr == ADDR_CTRL);

    fade_prescaler #(.PRESCALE_LSB(PRESCALE_LSB)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .rate    (rate_r),
        .rate_wr (rate_wr),
        .freeze  (ctrl_r[CTRL_FREEZE]),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) target_r[i] <= '0;
            rate_r       <= '0;
            ctrl_r       <= 2'b01;
            copy_pending <= 1'b0;
        end else begin
            // Dropping fade_en snaps every level to its target one cycle later.
            copy_pending <= ctrl_wr && ctrl_r[CTRL_FADE_EN] && !bus.wdata[CTRL_FADE_EN];
            if (tgt_wr)  target_r[tgt_idx] <= bus.wdata;
            if (rate_wr) rate_r            <= bus.wdata;
            if (ctrl_wr) ctrl_r            <= bus.wdata[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) level_r[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (level_r[ptr] < target_r[ptr])      level_r[ptr] <= level_r[ptr] + 8'd1;
                    else if (level_r[ptr] > target_r[ptr]) level_r[ptr] <= level_r[ptr] - 8'd1;
                    if (ptr == PW'(NUM_CH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (copy_pending) begin
                for (int i = 0; i < NUM_CH; i++) level_r[i] <= target_r[i];
            end
            if (tgt_wr && !ctrl_r[CTRL_FADE_EN]) level_r[tgt_idx] <= bus.wdata;
        end
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (level_r[i] != target_r[i]) all_eq = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) settled <= 1'b1;
        else        settled <= all_eq;
    end

    always_comb begin
        bus.rdata = 8'h00;
        if (tgt_rd)                       bus.rdata = target_r[tgt_idx];
        else if (bus.addr == ADDR_RATE)   bus.rdata = rate_r;
        else if (bus.addr == ADDR_CTRL)   bus.rdata = {6'b0, ctrl_r};
        else if (lvl_rd)                  bus.rdata = level_r[lvl_idx];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_level
        assign level[8*g +: 8] = level_r[g];
    end

endmodule
